// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encodings and digit width for the stopwatch
package stopwatch_ctrl_pkg;

    localparam int DIGIT_W = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } sw_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability debouncer and rising-edge press pulse
module btn_debounce #(
    parameter int DB_LIMIT = 500000,
    parameter int DB_CNT_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);

    logic                sync_a;
    logic                sync_b;
    logic                level;
    logic                level_d;
    logic [DB_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_d <= level;
            // Any bounce back to the current level restarts the stability window.
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LIMIT_M1) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM with lap freeze and sticky overflow
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_LIMIT = 500000,
    parameter int DB_CNT_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_lap,
    input  logic [DIGIT_W-1:0] count_in,
    input  logic               carry_in,
    output logic               count_enable,
    output logic               count_clear,
    output logic [DIGIT_W-1:0] disp_digits,
    output logic               lap_active,
    output logic               overflow,
    output logic [1:0]         state
);

    logic               start_press;
    logic               lap_press;
    sw_state_t          cur;
    sw_state_t          nxt;
    logic               latch_req;
    logic               release_req;
    logic               clear_req;
    logic               ovf_hit;
    logic               frozen;
    logic [DIGIT_W-1:0] freeze_reg;

    btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_press)
    );

    assign count_enable = (cur == S_RUN) || (cur == S_LAP);
    assign ovf_hit      = carry_in && count_enable;

    always_comb begin
        nxt         = cur;
        latch_req   = 1'b0;
        release_req = 1'b0;
        clear_req   = 1'b0;
        // Start is tested first in every state, so a coincident lap pulse is dropped.
        case (cur)
            S_IDLE: begin
                if (start_press) nxt = S_RUN;
            end
            S_RUN: begin
                if (start_press) begin
                    nxt = S_STOP;
                end else if (lap_press) begin
                    nxt       = S_LAP;
                    latch_req = 1'b1;
                end
            end
            S_LAP: begin
                if (start_press) begin
                    nxt = S_STOP;
                end else if (lap_press) begin
                    nxt         = S_RUN;
                    release_req = 1'b1;
                end
            end
            S_STOP: begin
                if (start_press) begin
                    nxt = frozen ? S_LAP : S_RUN;
                end else if (lap_press) begin
                    nxt         = S_IDLE;
                    release_req = 1'b1;
                    clear_req   = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (ovf_hit) begin
            nxt         = S_STOP;
            latch_req   = 1'b0;
            release_req = 1'b0;
            clear_req   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= S_IDLE;
            frozen      <= 1'b0;
            freeze_reg  <= '0;
            overflow    <= 1'b0;
            count_clear <= 1'b0;
        end else begin
            cur         <= nxt;
            count_clear <= clear_req;
            if (latch_req) begin
                freeze_reg <= count_in;
                frozen     <= 1'b1;
            end else if (release_req) begin
                frozen <= 1'b0;
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end else if (clear_req) begin
                overflow <= 1'b0;
            end
        end
    end

    assign lap_active  = frozen;
    assign disp_digits = frozen ? freeze_reg : count_in;
    assign state       = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench: stimulus queues expected transitions, monitor checks them
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start;
    logic        btn_lap;
    logic [23:0] count_in;
    logic        carry_in;
    logic        count_enable;
    logic        count_clear;
    logic [23:0] disp_digits;
    logic        lap_active;
    logic        overflow;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cycles = 0;
    logic [29:0] exp_q[$];

    stopwatch_ctrl #(.DB_LIMIT(4), .DB_CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start    (btn_start),
        .btn_lap      (btn_lap),
        .count_in     (count_in),
        .carry_in     (carry_in),
        .count_enable (count_enable),
        .count_clear  (count_clear),
        .disp_digits  (disp_digits),
        .lap_active   (lap_active),
        .overflow     (overflow),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Record layout: {state, count_enable, lap_active, overflow, count_clear, disp_digits}
    task automatic expect_tr(input logic [1:0] st, input logic en, input logic lap,
                             input logic ovf, input logic clr, input logic [23:0] disp);
        exp_q.push_back({st, en, lap, ovf, clr, disp});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic press(input logic s, input logic l, input string name);
        btn_start = s;
        btn_lap   = l;
        repeat (8) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (8) @(negedge clk);
        drain(name);
    endtask

    // Press start while carry_in pulses in exactly the cycle the press pulse is high.
    task automatic press_with_carry(input logic s, input logic l, input string name);
        btn_start = s;
        btn_lap   = l;
        repeat (6) @(negedge clk);
        carry_in = 1'b1;
        @(negedge clk);
        carry_in = 1'b0;
        repeat (3) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (8) @(negedge clk);
        drain(name);
    endtask

    initial begin : monitor
        logic [1:0]  prev_state = 2'd0;
        logic        clr_prev   = 1'b0;
        logic [29:0] act;
        forever begin
            @(negedge clk);
            act = {state, count_enable, lap_active, overflow, count_clear, disp_digits};
            if (state != prev_state) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transition: state %0d -> %0d at %0t", prev_state, state, $time);
                end else begin
                    chk("transition", {2'b0, act}, {2'b0, exp_q.pop_front()});
                end
            end
            if (count_clear) begin
                clr_cycles++;
                chk("clear_width", {31'b0, clr_prev}, 32'd0);
            end
            prev_state = state;
            clr_prev   = count_clear;
        end
    end

    initial begin : stimulus
        int clr_base;
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        count_in  = 24'h000000;
        carry_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {state, count_enable, count_clear, lap_active, overflow, disp_digits},
            {2'd0, 4'b0000, 24'h000000});
        reset = 1'b0;
        @(negedge clk);

        // A 2-cycle glitch never survives the stability window.
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_idle", state, 2'd0);

        // Held start: RUN after ~7 cycles and stays there while held.
        count_in = 24'h000042;
        expect_tr(2'd1, 1, 0, 0, 0, 24'h000042);
        btn_start = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_run", {state, count_enable}, {2'd1, 1'b1});
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        drain("start_held");

        // Lap freeze and release.
        count_in = 24'h001234;
        expect_tr(2'd3, 1, 1, 0, 0, 24'h001234);
        press(0, 1, "lap_enter");
        count_in = 24'h001300;
        @(negedge clk);
        chk("frozen_disp", {lap_active, disp_digits}, {1'b1, 24'h001234});
        expect_tr(2'd1, 1, 0, 0, 0, 24'h001300);
        press(0, 1, "lap_release");

        // Stop then clear.
        expect_tr(2'd2, 0, 0, 0, 0, 24'h001300);
        press(1, 0, "stop");
        clr_base = clr_cycles;
        expect_tr(2'd0, 0, 0, 0, 1, 24'h001300);
        press(0, 1, "clear");
        chk("clear_cycles", clr_cycles - clr_base, 1);

        // Overflow in RUN with a coincident start press.
        count_in = 24'h999999;
        expect_tr(2'd1, 1, 0, 0, 0, 24'h999999);
        press(1, 0, "run2");
        expect_tr(2'd2, 0, 0, 1, 0, 24'h999999);
        press_with_carry(1, 0, "ovf_run");
        chk("ovf_sticky", {state, overflow, count_enable}, {2'd2, 1'b1, 1'b0});
        expect_tr(2'd0, 0, 0, 0, 1, 24'h999999);
        press(0, 1, "clear_ovf");

        // Overflow in LAP beats a lap-release press; frozen display is kept.
        count_in = 24'h000500;
        expect_tr(2'd1, 1, 0, 0, 0, 24'h000500);
        press(1, 0, "run3");
        expect_tr(2'd3, 1, 1, 0, 0, 24'h000500);
        press(0, 1, "lap3");
        count_in = 24'h000600;
        expect_tr(2'd2, 0, 1, 1, 0, 24'h000500);
        press_with_carry(0, 1, "ovf_lap");
        // STOP with display frozen resumes into LAP.
        expect_tr(2'd3, 1, 1, 1, 0, 24'h000500);
        press(1, 0, "resume_lap");
        expect_tr(2'd2, 0, 1, 1, 0, 24'h000500);
        press(1, 0, "stop_from_lap");
        expect_tr(2'd0, 0, 0, 0, 1, 24'h000600);
        press(0, 1, "clear_lap");

        // Simultaneous presses: start wins.
        count_in = 24'h000010;
        expect_tr(2'd1, 1, 0, 0, 0, 24'h000010);
        press(1, 0, "run4");
        expect_tr(2'd2, 0, 0, 0, 0, 24'h000010);
        press(1, 1, "both");

        // Reset mid-LAP clears everything immediately.
        expect_tr(2'd1, 1, 0, 0, 0, 24'h000010);
        press(1, 0, "run5");
        count_in = 24'h000777;
        expect_tr(2'd3, 1, 1, 0, 0, 24'h000777);
        press(0, 1, "lap5");
        count_in = 24'h000000;
        expect_tr(2'd0, 0, 0, 0, 0, 24'h000000);
        #1 reset = 1'b1;
        #1 chk("reset_async", {state, count_enable, count_clear, lap_active, overflow, disp_digits},
               {2'd0, 4'b0000, 24'h000000});
        @(negedge clk);
        drain("reset_lap");

        // A button held through reset yields exactly one press once debounced.
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        expect_tr(2'd1, 1, 0, 0, 0, 24'h000000);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        drain("held_through_reset");
        chk("final_run", {state, count_enable}, {2'd1, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 500000; debounce stability cycles (bench uses 4).
REQ-002 SHALL have parameter DB_CNT_W, default 20; debounce counter width; must hold DB_LIMIT.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_start  input  1  raw start/stop push-button, asynchronous, active-high.
REQ-006 SHALL have port btn_lap  input  1  raw lap/clear push-button, asynchronous, active-high.
REQ-007 SHALL have port count_in  input  24  six BCD digits from the counter datapath, digit 5 in [23:20].
REQ-008 SHALL have port carry_in  input  1  counter overflow carry, synchronous to clk.
REQ-009 SHALL have port count_enable  output  1  enable to the counter datapath.
REQ-010 SHALL have port count_clear  output  1  one-cycle synchronous clear to the counter datapath.
REQ-011 SHALL have port disp_digits  output  24  digits to the 7-seg scanner, live or frozen.
REQ-012 SHALL have port lap_active  output  1  high while the display is frozen.
REQ-013 SHALL have port overflow  output  1  sticky overflow flag.
REQ-014 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-015 SHALL pass each button through a 2-FF synchronizer, then a debouncer whose level changes only after the synchronized input stays at the new value for DB_LIMIT consecutive cycles.
REQ-016 SHALL produce a one-cycle press pulse on each rising edge of a debounced level; a held button produces no further pulses; releases produce none.
REQ-017 SHALL implement states IDLE=0, RUN=1, STOP=2, LAP=3, registered, with transitions taking effect one cycle after the press pulse.
REQ-018 IDLE: start -> RUN; lap ignored.
REQ-019 RUN: start -> STOP; lap -> LAP and latch count_in into the freeze register in the same edge.
REQ-020 LAP: start -> STOP, display stays frozen; lap -> RUN, display returns to live.
REQ-021 STOP: start -> RUN, or -> LAP if frozen; lap -> IDLE with count_clear high for exactly one cycle, freeze released, overflow cleared.
REQ-022 Simultaneous start and lap pulses in the same cycle: start has priority; the lap pulse is discarded.
REQ-023 count_enable SHALL be high exactly in RUN and LAP, decoded from the registered state, with no combinational path from buttons.
REQ-024 carry_in high while count_enable is high SHALL set overflow and force STOP on the next edge; this overrides any concurrent press.
REQ-025 disp_digits SHALL equal count_in combinationally when not frozen, and the freeze register when lap_active is high.
REQ-026 lap_active SHALL be high from entry to LAP until lap release in LAP or clear in STOP.

Reset
REQ-027 Reset SHALL asynchronously force: state=IDLE, count_enable=0, count_clear=0, lap_active=0, overflow=0, freeze register=0, synchronizers/debounce levels=0, debounce counters=0.
REQ-028 After reset deassertion, a button already held SHALL generate one press once debounced.
REQ-029 Reset mid-debounce or mid-lap SHALL discard all pending presses and the frozen value.

Structure
REQ-030 SHALL place state encodings (S_IDLE..S_LAP) and the 24-bit digit width in a shared constants file used by the counter top level.
REQ-031 SHALL use one sub-module, btn_debounce (sync + debounce + edge pulse), instantiated twice; the FSM stays in stopwatch_ctrl.

Verification
REQ-032 With DB_LIMIT=4: 2-cycle btn_start glitch -> no pulse, state stays IDLE.
REQ-033 btn_start held 10 cycles from IDLE -> state=RUN, count_enable=1 after ~7 cycles; remains RUN while held.
REQ-034 In RUN with count_in=24'h001234, press lap, then change count_in to 24'h001300 -> disp_digits stays 24'h001234, lap_active=1; press lap again -> disp_digits=24'h001300.
REQ-035 RUN -> start (STOP) -> lap -> count_clear high exactly 1 cycle, state=IDLE, lap_active=0.
REQ-036 In RUN, carry_in=1 for one cycle -> overflow=1, state=STOP, count_enable=0; a start press in the same cycle -> state still STOP.
REQ-037 Both buttons pressed in the same cycle from RUN -> state=STOP, lap_active=0; reset asserted mid-LAP -> all outputs 0 immediately.
